// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store initiator: funct3 codes, FSM states
// and the access-size byte mask helper.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ1,
    ST_WAIT1,
    ST_REQ2,
    ST_WAIT2,
    ST_RESP
  } lsu_state_e;

  // funct3[1:0] encodes log2 of the access size for every legal opcode
  function automatic logic [3:0] size_mask(input logic [1:0] size_log2);
    case (size_log2)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Execute-side request/response and memory-side bus of the load/store initiator.
interface lsu_mem_initiator_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  mem_req;
  logic                  mem_gnt;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: rotates store data into lanes and combines, shifts and
// extends load data from one or two memory words.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] wdata_rot,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  output logic [31:0] rdata_ext
);
  logic [4:0]  sh;
  logic [31:0] comb;

  always_comb begin
    sh        = {offset, 3'b000};
    wdata_rot = (wdata << sh) | (wdata >> (6'd32 - {1'b0, sh}));
    comb      = 32'({rdata2, rdata1} >> sh);
    case (funct3)
      LB:      rdata_ext = {{24{comb[7]}}, comb[7:0]};
      LH:      rdata_ext = {{16{comb[15]}}, comb[15:0]};
      LBU:     rdata_ext = {24'h000000, comb[7:0]};
      LHU:     rdata_ext = {16'h0000, comb[15:0]};
      default: rdata_ext = comb;
    endcase
  end
endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: decodes one request, issues word-aligned memory traffic
// and returns one response. Define LSU_MISALIGN_SPLIT_EN to split crossing accesses.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_RSP_WAIT = 15
) (
  input logic                 clk,
  input logic                 rst_n,
  lsu_mem_initiator_if.master bus
);
  localparam int CW = (MAX_RSP_WAIT > 1) ? $clog2(MAX_RSP_WAIT) : 1;

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("lsu_mem_initiator: DATA_WIDTH must be 32");
  end

  lsu_state_e            state, state_nx;
  logic [2:0]            f3;
  logic [1:0]            off;
  logic                  legal, dec_err, timeout;
  logic                  we_q, err_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata1_q, rdata2_in, wdata_rot, rdata_ext;
  logic [3:0]            be1_q;
  logic [CW-1:0]         cnt_q;

  assign f3  = bus.req_funct3;
  assign off = bus.req_addr[1:0];

  always_comb begin
    if (bus.req_we) legal = (f3 == SB) || (f3 == SH) || (f3 == SW);
    else            legal = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [7:0]            raw_be;
  logic                  cross, split_q;
  logic [3:0]            be2_q;
  logic [DATA_WIDTH-1:0] rdata2_q;
  assign raw_be    = {4'b0000, size_mask(f3[1:0])} << off;
  assign cross     = |raw_be[7:4];
  assign dec_err   = !legal;
  assign rdata2_in = rdata2_q;
`else
  logic [3:0] raw_be;
  logic       misal;
  assign raw_be    = size_mask(f3[1:0]) << off;
  assign misal     = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  assign dec_err   = !legal || misal;
  assign rdata2_in = '0;
`endif

  assign timeout = (cnt_q == CW'(MAX_RSP_WAIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (bus.req_valid) state_nx = dec_err ? ST_RESP : ST_REQ1;
      ST_REQ1:  if (bus.mem_gnt) state_nx = ST_WAIT1;
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_WAIT1: if (bus.mem_rvalid) state_nx = split_q ? ST_REQ2 : ST_RESP;
                else if (timeout)   state_nx = ST_RESP;
      ST_REQ2:  if (bus.mem_gnt) state_nx = ST_WAIT2;
      ST_WAIT2: if (bus.mem_rvalid || timeout) state_nx = ST_RESP;
`else
      ST_WAIT1: if (bus.mem_rvalid || timeout) state_nx = ST_RESP;
`endif
      ST_RESP:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      f3_q     <= '0;
      off_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata1_q <= '0;
      be1_q    <= '0;
      cnt_q    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q  <= 1'b0;
      be2_q    <= '0;
      rdata2_q <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (bus.req_valid) begin
          we_q     <= bus.req_we;
          err_q    <= dec_err;
          f3_q     <= f3;
          off_q    <= off;
          addr_q   <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_q  <= bus.req_wdata;
          rdata1_q <= '0;
          be1_q    <= raw_be[3:0];
`ifdef LSU_MISALIGN_SPLIT_EN
          split_q  <= cross;
          be2_q    <= raw_be[7:4];
          rdata2_q <= '0;
`endif
        end
        ST_REQ1, ST_REQ2: if (bus.mem_gnt) cnt_q <= '0;
        ST_WAIT1: begin
          if (bus.mem_rvalid) rdata1_q <= bus.mem_rdata;
          else if (timeout)   err_q    <= 1'b1;
          else                cnt_q    <= cnt_q + 1'b1;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ST_WAIT2: begin
          if (bus.mem_rvalid) rdata2_q <= bus.mem_rdata;
          else if (timeout)   err_q    <= 1'b1;
          else                cnt_q    <= cnt_q + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  lsu_lane_align u_align (
    .offset    (off_q),
    .funct3    (f3_q),
    .wdata     (wdata_q),
    .wdata_rot (wdata_rot),
    .rdata1    (rdata1_q),
    .rdata2    (rdata2_in),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    bus.req_ready = (state == ST_IDLE);
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = '0;
    case (state)
      ST_REQ1: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_be    = be1_q;
        bus.mem_wdata = wdata_rot;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_REQ2: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q + ADDR_WIDTH'(4);
        bus.mem_be    = be2_q;
        bus.mem_wdata = wdata_rot;
      end
`endif
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        bus.rsp_rdata = (err_q || we_q) ? '0 : rdata_ext;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator; expectations adapt to LSU_MISALIGN_SPLIT_EN.
module tb_lsu_mem_initiator;
  localparam int MAXW = 15;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nmem;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [3:0]  be0;
    logic [3:0]  be1;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  // observations recorded by run_op
  bit          obs_done, obs_rsp_next, obs_ready0, obs_ready_busy;
  int          obs_lat, obs_gnt_t, obs_nmem;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic [31:0] obs_addr[2];
  logic [3:0]  obs_be[2];
  logic        obs_we[2];
  logic [31:0] obs_wdata[2];

  lsu_mem_initiator_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  lsu_mem_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_RSP_WAIT(MAXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_load(input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] w1, input logic [31:0] w2, input int gd);
    exp_t        e;
    logic [7:0]  b[8];
    logic [31:0] raw;
    int          size, off;
    bit          crossing, aligned;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) begin
      b[i]     = w1[8*i +: 8];
      b[i + 4] = w2[8*i +: 8];
    end
    e.be0 = 4'b0000;
    e.be1 = 4'b0000;
    raw   = 32'h0;
    for (int i = 0; i < size; i++) begin
      if (off + i < 4) e.be0[off + i] = 1'b1;
      else             e.be1[off + i - 4] = 1'b1;
      raw[8*i +: 8] = b[off + i];
    end
    crossing = (off + size) > 4;
    aligned  = (off % size) == 0;
`ifdef LSU_MISALIGN_SPLIT_EN
    e.err = 1'b0;
`else
    e.err = !aligned;
`endif
    e.nmem = e.err ? 0 : (crossing ? 2 : 1);
    e.lat  = e.err ? 1 : (crossing ? 5 + 2 * gd : 3 + gd);
    case (f3)
      3'b000:  e.rdata = {{24{raw[7]}}, raw[7:0]};
      3'b001:  e.rdata = {{16{raw[15]}}, raw[15:0]};
      3'b100:  e.rdata = {24'h0, raw[7:0]};
      3'b101:  e.rdata = {16'h0, raw[15:0]};
      default: e.rdata = raw;
    endcase
    if (e.err) e.rdata = 32'h0;
    e.addr0 = {addr[31:2], 2'b00};
    e.addr1 = e.addr0 + 32'd4;
    e.we    = 1'b0;
    e.wdata = 32'h0;
    return e;
  endfunction

  // Drives one request and plays a memory with gd grant-wait cycles and rvalid
  // one cycle after each grant; records what the DUT did.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd1, input logic [31:0] rd2,
                        input int gd, input bit give_rv);
    int          t, wcnt, ntx;
    bit          in_req, pend;
    logic [31:0] pdata;
    obs_done = 0; obs_lat = -1; obs_gnt_t = -1; obs_rdata = 'x; obs_err = 'x;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    obs_ready0 = bus.req_ready;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b111;
    bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = 32'h0;
    obs_ready_busy = bus.req_ready;
    t = 1; in_req = 0; pend = 0; wcnt = 0; ntx = 0; pdata = 32'h0;
    while (t < 80) begin
      bus.mem_rvalid = pend;
      bus.mem_rdata  = pend ? pdata : 32'hA5A5_A5A5;
      pend = 0;
      bus.mem_gnt = 1'b0;
      if (bus.mem_req) begin
        if (!in_req) begin
          if (ntx < 2) begin
            obs_addr[ntx] = bus.mem_addr; obs_be[ntx] = bus.mem_be;
            obs_we[ntx] = bus.mem_we; obs_wdata[ntx] = bus.mem_wdata;
          end
          ntx++; in_req = 1; wcnt = 0;
        end
        if (wcnt == gd) begin
          bus.mem_gnt = 1'b1; in_req = 0; obs_gnt_t = t;
          if (give_rv) begin pend = 1; pdata = (ntx == 1) ? rd1 : rd2; end
        end else wcnt++;
      end
      if (bus.rsp_valid) begin
        obs_done = 1; obs_lat = t; obs_rdata = bus.rsp_rdata; obs_err = bus.rsp_err;
        break;
      end
      @(posedge clk); #1;
      t++;
    end
    obs_nmem = ntx;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    @(posedge clk); #1;
    obs_rsp_next = bus.rsp_valid;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      $display("FAIL reset_ctrl: ready/req/rsp_valid=%b%b%b required 100", bus.req_ready, bus.mem_req, bus.rsp_valid);
    end else n_pass++;
    n_checks++;
    if ({bus.mem_addr, bus.mem_be, bus.mem_we, bus.mem_wdata, bus.rsp_rdata, bus.rsp_err} !== '0) begin
      $display("FAIL reset_data: addr=%h be=%b we=%b wdata=%h rdata=%h err=%b required all 0",
               bus.mem_addr, bus.mem_be, bus.mem_we, bus.mem_wdata, bus.rsp_rdata, bus.rsp_err);
    end else n_pass++;
  endtask

  task automatic test_aligned_store();
    exp_t e;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 3, nmem: 1, addr0: 32'h10, addr1: 32'h0,
                      be0: 4'b1111, be1: 4'b0, we: 1'b1, wdata: 32'hDEAD_BEEF});
    run_op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0, 0, 1);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_ready0 !== 1'b1 || obs_ready_busy !== 1'b0) begin
      $display("FAIL sw_ready: idle=%b busy=%b required 1 0", obs_ready0, obs_ready_busy);
    end else n_pass++;
    n_checks++;
    if (obs_lat !== e.lat || obs_err !== e.err || obs_rdata !== e.rdata) begin
      $display("FAIL sw_rsp: lat=%0d err=%b rdata=%h required %0d %b %h", obs_lat, obs_err, obs_rdata, e.lat, e.err, e.rdata);
    end else n_pass++;
    n_checks++;
    if (obs_nmem !== e.nmem || obs_addr[0] !== e.addr0 || obs_be[0] !== e.be0 ||
        obs_we[0] !== e.we || obs_wdata[0] !== e.wdata) begin
      $display("FAIL sw_mem: n=%0d addr=%h be=%b we=%b wdata=%h required %0d %h %b %b %h", obs_nmem,
               obs_addr[0], obs_be[0], obs_we[0], obs_wdata[0], e.nmem, e.addr0, e.be0, e.we, e.wdata);
    end else n_pass++;
    n_checks++;
    if (obs_rsp_next !== 1'b0) begin
      $display("FAIL sw_pulse: rsp_valid after RESP=%b required 0", obs_rsp_next);
    end else n_pass++;
  endtask

  task automatic test_byte_load();
    exp_t e;
    exp_q.push_back('{rdata: 32'hFFFF_FF80, err: 1'b0, lat: 3, nmem: 1, addr0: 32'h10, addr1: 32'h0,
                      be0: 4'b1000, be1: 4'b0, we: 1'b0, wdata: 32'h0});
    exp_q.push_back('{rdata: 32'h0000_0080, err: 1'b0, lat: 3, nmem: 1, addr0: 32'h10, addr1: 32'h0,
                      be0: 4'b1000, be1: 4'b0, we: 1'b0, wdata: 32'h0});
    for (int i = 0; i < 2; i++) begin
      run_op(1'b0, (i == 0) ? 3'b000 : 3'b100, 32'h13, 32'h0, 32'h8012_3456, 32'h0, 0, 1);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_rdata !== e.rdata || obs_err !== e.err || obs_lat !== e.lat) begin
        $display("FAIL lb_rsp%0d: rdata=%h err=%b lat=%0d required %h %b %0d", i, obs_rdata, obs_err, obs_lat, e.rdata, e.err, e.lat);
      end else n_pass++;
      n_checks++;
      if (obs_be[0] !== e.be0 || obs_addr[0] !== e.addr0 || obs_we[0] !== e.we) begin
        $display("FAIL lb_mem%0d: be=%b addr=%h we=%b required %b %h %b", i, obs_be[0], obs_addr[0], obs_we[0], e.be0, e.addr0, e.we);
      end else n_pass++;
    end
  endtask

  task automatic test_half();
    exp_t e;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 4, nmem: 1, addr0: 32'h10, addr1: 32'h0,
                      be0: 4'b1100, be1: 4'b0, we: 1'b1, wdata: 32'h1234_0000});
    run_op(1'b1, 3'b001, 32'h12, 32'h0000_1234, 32'h0, 32'h0, 1, 1);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_be[0] !== e.be0 || obs_wdata[0] !== e.wdata || obs_we[0] !== e.we || obs_lat !== e.lat) begin
      $display("FAIL sh_mem: be=%b wdata=%h we=%b lat=%0d required %b %h %b %0d", obs_be[0], obs_wdata[0], obs_we[0], obs_lat, e.be0, e.wdata, e.we, e.lat);
    end else n_pass++;
    exp_q.push_back('{rdata: 32'h0000_1234, err: 1'b0, lat: 3, nmem: 1, addr0: 32'h10, addr1: 32'h0,
                      be0: 4'b1100, be1: 4'b0, we: 1'b0, wdata: 32'h0});
    run_op(1'b0, 3'b101, 32'h12, 32'h0, 32'h1234_0000, 32'h0, 0, 1);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_rdata !== e.rdata || obs_err !== e.err || obs_be[0] !== e.be0) begin
      $display("FAIL lhu_rsp: rdata=%h err=%b be=%b required %h %b %b", obs_rdata, obs_err, obs_be[0], e.rdata, e.err, e.be0);
    end else n_pass++;
  endtask

  task automatic test_cross();
    exp_t e;
`ifdef LSU_MISALIGN_SPLIT_EN
    exp_q.push_back('{rdata: 32'hCCCC_BBBB, err: 1'b0, lat: 5, nmem: 2, addr0: 32'h0C, addr1: 32'h10,
                      be0: 4'b1100, be1: 4'b0011, we: 1'b0, wdata: 32'h0});
    exp_q.push_back('{rdata: 32'h7788_1122, err: 1'b0, lat: 5, nmem: 2, addr0: 32'hFFFF_FFFC, addr1: 32'h0,
                      be0: 4'b1100, be1: 4'b0011, we: 1'b0, wdata: 32'h0});
`else
    exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 1, nmem: 0, addr0: 32'h0, addr1: 32'h0,
                      be0: 4'b0, be1: 4'b0, we: 1'b0, wdata: 32'h0});
    exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 1, nmem: 0, addr0: 32'h0, addr1: 32'h0,
                      be0: 4'b0, be1: 4'b0, we: 1'b0, wdata: 32'h0});
`endif
    for (int i = 0; i < 2; i++) begin
      if (i == 0) run_op(1'b0, 3'b010, 32'h0E, 32'h0, 32'hBBBB_AAAA, 32'hDDDD_CCCC, 0, 1);
      else        run_op(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 32'h1122_3344, 32'h5566_7788, 0, 1);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_rdata !== e.rdata || obs_err !== e.err || obs_lat !== e.lat || obs_nmem !== e.nmem) begin
        $display("FAIL lw_cross%0d: rdata=%h err=%b lat=%0d n=%0d required %h %b %0d %0d", i,
                 obs_rdata, obs_err, obs_lat, obs_nmem, e.rdata, e.err, e.lat, e.nmem);
      end else n_pass++;
      if (e.nmem == 2) begin
        n_checks++;
        if (obs_addr[0] !== e.addr0 || obs_be[0] !== e.be0 || obs_addr[1] !== e.addr1 || obs_be[1] !== e.be1) begin
          $display("FAIL lw_cross_mem%0d: %h/%b %h/%b required %h/%b %h/%b", i, obs_addr[0], obs_be[0],
                   obs_addr[1], obs_be[1], e.addr0, e.be0, e.addr1, e.be1);
        end else n_pass++;
      end
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 1, nmem: 0, addr0: 32'h0, addr1: 32'h0,
                        be0: 4'b0, be1: 4'b0, we: 1'b0, wdata: 32'h0});
      if (i == 0) run_op(1'b0, 3'b011, 32'h10, 32'h0, 32'h1111_1111, 32'h0, 0, 1);
      else        run_op(1'b1, 3'b100, 32'h10, 32'h5555_5555, 32'h0, 32'h0, 0, 1);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_err !== e.err || obs_rdata !== e.rdata || obs_lat !== e.lat || obs_nmem !== e.nmem) begin
        $display("FAIL illegal%0d: err=%b rdata=%h lat=%0d n=%0d required %b %h %0d %0d", i,
                 obs_err, obs_rdata, obs_lat, obs_nmem, e.err, e.rdata, e.lat, e.nmem);
      end else n_pass++;
    end
  endtask

  task automatic test_load_sweep();
    logic [2:0]  lf[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [31:0] w1, w2, addr;
    exp_t        e;
    int          gd;
    for (int f = 0; f < 5; f++) begin
      for (int o = 0; o < 4; o++) begin
        w1 = $urandom; w2 = $urandom;
        addr = 32'h40 + 32'(o);
        gd = (f + o) % 3;
        exp_q.push_back(model_load(lf[f], addr, w1, w2, gd));
        run_op(1'b0, lf[f], addr, 32'h0, w1, w2, gd, 1);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_rdata !== e.rdata || obs_err !== e.err || obs_lat !== e.lat || obs_nmem !== e.nmem) begin
          $display("FAIL sweep f3=%b off=%0d: rdata=%h err=%b lat=%0d n=%0d required %h %b %0d %0d", lf[f], o,
                   obs_rdata, obs_err, obs_lat, obs_nmem, e.rdata, e.err, e.lat, e.nmem);
        end else n_pass++;
        if (e.nmem > 0) begin
          n_checks++;
          if (obs_addr[0] !== e.addr0 || obs_be[0] !== e.be0 || (e.nmem == 2 && obs_be[1] !== e.be1)) begin
            $display("FAIL sweep_mem f3=%b off=%0d: addr=%h be=%b be2=%b required %h %b %b", lf[f], o,
                     obs_addr[0], obs_be[0], obs_be[1], e.addr0, e.be0, e.be1);
          end else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h30;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if (bus.mem_req !== 1'b1) begin
      $display("FAIL rst_hold: mem_req=%b required 1", bus.mem_req);
    end else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1) begin
      $display("FAIL rst_async: mem_req=%b ready=%b required 0 1", bus.mem_req, bus.req_ready);
    end else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
        $display("FAIL rst_late_rvalid%0d: rsp_valid=%b ready=%b mem_req=%b required 0 1 0", i,
                 bus.rsp_valid, bus.req_ready, bus.mem_req);
      end else n_pass++;
    end
    bus.mem_rvalid = 1'b0;
    exp_q.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0, lat: 3, nmem: 1, addr0: 32'h30, addr1: 32'h0,
                      be0: 4'b1111, be1: 4'b0, we: 1'b0, wdata: 32'h0});
    run_op(1'b0, 3'b010, 32'h30, 32'h0, 32'h0BAD_F00D, 32'h0, 0, 1);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_rdata !== e.rdata || obs_err !== e.err || obs_lat !== e.lat || obs_addr[0] !== e.addr0) begin
      $display("FAIL rst_after: rdata=%h err=%b lat=%0d addr=%h required %h %b %0d %h", obs_rdata, obs_err,
               obs_lat, obs_addr[0], e.rdata, e.err, e.lat, e.addr0);
    end else n_pass++;
  endtask

  task automatic test_timeout();
    int waited;
    run_op(1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 32'h0, 0, 0);
    waited = obs_lat - obs_gnt_t;
    n_checks++;
    if (obs_done !== 1'b1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
      $display("FAIL timeout_rsp: done=%b err=%b rdata=%h required 1 1 00000000", obs_done, obs_err, obs_rdata);
    end else n_pass++;
    n_checks++;
    if (waited < MAXW || waited > MAXW + 1) begin
      $display("FAIL timeout_cycles: grant-to-rsp=%0d required %0d..%0d", waited, MAXW, MAXW + 1);
    end else n_pass++;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_aligned_store();
    test_byte_load();
    test_half();
    test_cross();
    test_illegal();
    test_load_sweep();
    test_reset_midflight();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
